// File: rtl/circuit_preimage_search.sv
// circuit_preimage_search: exhaustive 32-vector preimage search over the 5-in/5-out random-logic function
module circuit_preimage_search #(
  parameter bit FIRST_ONLY = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_target,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_found,
  output logic [4:0] rsp_in,
  output logic [5:0] rsp_count,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] cand_q, cand_d, target_q, target_d, in_q, in_d, f;
  logic [5:0] count_q, count_d;
  logic found_q, found_d, match;
  // forward function evaluated on the current candidate
  always_comb begin
    f[0] = ~cand_q[0] & ~cand_q[2];
    f[1] = ~cand_q[2] & (~cand_q[1] | ~cand_q[0]);
    f[2] = ~cand_q[0] & ~cand_q[2] & ~cand_q[4];
    f[3] = 1'b1;
    f[4] = cand_q[0] | cand_q[2] | (~cand_q[3] & cand_q[4]);
  end
  assign match = f == target_q;
  // request accept, one candidate per search cycle, response hold until taken
  always_comb begin
    state_d = state_q;
    cand_d = cand_q;
    target_d = target_q;
    in_d = in_q;
    count_d = count_q;
    found_d = found_q;
    case (state_q)
      IDLE: if (req_valid) begin
        target_d = req_target;
        cand_d = 5'd0;
        count_d = 6'd0;
        found_d = 1'b0;
        in_d = 5'd0;
        state_d = SEARCH;
      end
      SEARCH: begin
        count_d = match ? count_q + 6'd1 : count_q;
        found_d = found_q | match;
        in_d = (match && !found_q) ? cand_q : in_q;
        cand_d = cand_q + 5'd1;
        state_d = (cand_q == 5'd31 || (FIRST_ONLY && match)) ? DONE : SEARCH;
      end
      DONE: state_d = rsp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q <= 5'd0;
      target_q <= 5'd0;
      in_q <= 5'd0;
      count_q <= 6'd0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q <= cand_d;
      target_q <= target_d;
      in_q <= in_d;
      count_q <= count_d;
      found_q <= found_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == DONE;
  assign busy = state_q == SEARCH;
  assign rsp_found = found_q;
  assign rsp_in = in_q;
  assign rsp_count = count_q;
endmodule

// File: tb/tb_circuit_preimage_search.sv
// tb_circuit_preimage_search: scoreboard bench for full-scan and first-only instances
module tb_circuit_preimage_search;
  typedef struct {
    int inst;
    int found;
    int in;
    int cnt;
    int lat;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b1;
  logic [4:0] req_target = 5'd0;
  logic req_valid [2];
  logic rr [2], rv [2], rf [2], bz [2];
  logic [4:0] ri [2];
  logic [5:0] rc [2];
  exp_t q[$];
  exp_t cur [2];
  bit active [2];
  int tests = 0, fails = 0, cyc = 0, acc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  circuit_preimage_search #(.FIRST_ONLY(1'b0)) u_full (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(rr[0]), .req_target(req_target),
    .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_found(rf[0]), .rsp_in(ri[0]), .rsp_count(rc[0]), .busy(bz[0]));
  circuit_preimage_search #(.FIRST_ONLY(1'b1)) u_first (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(rr[1]), .req_target(req_target),
    .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_found(rf[1]), .rsp_in(ri[1]), .rsp_count(rc[1]), .busy(bz[1]));
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // monitor: pop an expectation when a response appears, recheck it every cycle it is held
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || !rv[i]) active[i] = 1'b0;
      else begin
        if (!active[i]) begin
          active[i] = 1'b1;
          if (q.size() == 0 || q[0].inst != i) begin
            chk($sformatf("unexpected_rsp%0d", i), 1, 0);
            cur[i] = '{i, rf[i], ri[i], rc[i], 0};
          end else begin
            cur[i] = q.pop_front();
            chk($sformatf("latency%0d", i), cyc - acc, cur[i].lat);
          end
        end
        chk($sformatf("found%0d", i), rf[i], cur[i].found);
        chk($sformatf("in%0d", i), ri[i], cur[i].in);
        chk($sformatf("count%0d", i), rc[i], cur[i].cnt);
        chk($sformatf("req_ready_in_done%0d", i), rr[i], 0);
      end
    end
  end
  task automatic req(input int i, input logic [4:0] t, input int f, input int in, input int cnt, input int lat, input bit push);
    @(negedge clk);
    if (push) q.push_back('{i, f, in, cnt, lat});
    req_target = t;
    for (int k = 0; k < 50 && !rr[i]; k++) @(negedge clk);
    if (!rr[i]) chk("req_ready_timeout", rr[i], 1);
    req_valid[i] = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid[i] = 1'b0;
    @(negedge clk);
    chk("busy_in_search", bz[i], 1);
    chk("req_ready_in_search", rr[i], 0);
  endtask
  task automatic wait_done();
    int k;
    for (k = 0; k < 200 && (q.size() != 0 || rv[0] || rv[1]); k++) @(negedge clk);
    if (k == 200) chk("rsp_timeout", q.size(), 0);
  endtask
  initial begin
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", rr[i], 1);
      chk("rst_rsp_valid", rv[i], 0);
      chk("rst_busy", bz[i], 0);
      chk("rst_found", rf[i], 0);
      chk("rst_in", ri[i], 0);
      chk("rst_count", rc[i], 0);
    end
    rst_n = 1'b1;
    req(0, 5'b11010, 1, 1, 4, 32, 1); wait_done();
    req(0, 5'b01111, 1, 0, 4, 32, 1); wait_done();
    req(0, 5'b11011, 1, 16, 2, 32, 1); wait_done();
    req(0, 5'b01000, 0, 0, 0, 32, 1); wait_done();
    req(0, 5'b00000, 0, 0, 0, 32, 1); wait_done();
    req(1, 5'b11011, 1, 16, 1, 17, 1); wait_done();
    req(1, 5'b11010, 1, 1, 1, 2, 1); wait_done();
    req(1, 5'b01000, 0, 0, 0, 32, 1); wait_done();
    rsp_ready = 1'b0;
    req(0, 5'b11010, 1, 1, 4, 32, 1);
    for (int k = 0; k < 60 && !rv[0]; k++) @(negedge clk);
    chk("hold_rsp_valid", rv[0], 1);
    repeat (10) @(negedge clk);
    chk("hold_rsp_valid_after10", rv[0], 1);
    chk("hold_req_ready", rr[0], 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_rsp_valid", rv[0], 0);
    chk("release_req_ready", rr[0], 1);
    req(0, 5'b11010, 1, 1, 4, 32, 0);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bz[0], 0);
    chk("midrst_rsp_valid", rv[0], 0);
    chk("midrst_req_ready", rr[0], 1);
    chk("midrst_count", rc[0], 0);
    chk("midrst_found", rf[0], 0);
    chk("midrst_in", ri[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    req(0, 5'b11010, 1, 1, 4, 32, 1); wait_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
